// File: rtl/fifo_pack.sv
// Shared FIFO definitions: word width plus the read-side packer's state
// type, default pack ratio and lane-count type.
package fifo_pack;

    localparam int FIFO_WIDTH         = 16;
    localparam int PACK_RATIO_DEFAULT = 4;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        OUT  = 1'b1
    } packer_state_e;

    typedef logic [$clog2(PACK_RATIO_DEFAULT):0] lane_cnt_t;

endpackage

// File: rtl/fifo_rd_packer_lane_reg.sv
// Lane storage for the read packer: indexed single-lane write, bulk clear,
// and the lanes presented as one concatenated word with lane 0 in the LSBs.
module packer_lane_reg #(
    parameter int DATA_WIDTH = 16,
    parameter int PACK_RATIO = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             wr_en,
    input  logic [$clog2(PACK_RATIO):0]      wr_idx,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] word
);

    localparam int IW = $clog2(PACK_RATIO);

    logic [DATA_WIDTH-1:0] lanes [PACK_RATIO];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PACK_RATIO; i++) lanes[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < PACK_RATIO; i++) lanes[i] <= '0;
        end else if (wr_en && (wr_idx < PACK_RATIO)) begin
            lanes[wr_idx[IW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < PACK_RATIO; i++) word[i*DATA_WIDTH +: DATA_WIDTH] = lanes[i];
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO words and packs PACK_RATIO of them into one valid/ready output word.
// Define PACKER_TIMEOUT_EN to auto-flush a partial word after TIMEOUT_CYCLES idle cycles.
module fifo_rd_packer
    import fifo_pack::*;
#(
    parameter int DATA_WIDTH     = FIFO_WIDTH,
    parameter int PACK_RATIO     = PACK_RATIO_DEFAULT,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             fifo_empty,
    input  logic [DATA_WIDTH-1:0]            fifo_data,
    output logic                             fifo_rd_en,
    input  logic                             flush,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [$clog2(PACK_RATIO):0]      out_lanes,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int CW = $clog2(PACK_RATIO) + 1;
    localparam int OW = DATA_WIDTH * PACK_RATIO;

    if (PACK_RATIO < 2 || PACK_RATIO > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("fifo_rd_packer: unsupported PACK_RATIO or TIMEOUT_CYCLES");
    end

    packer_state_e   state;
    logic [CW-1:0]   lane_cnt;
    logic            pend;
    logic            flush_q;
    logic            flush_req;
    logic            last_lane;
    logic [CW:0]     fill_level;
    logic [OW-1:0]   lane_word;
    logic [OW-1:0]   merged_word;

    assign fill_level = {1'b0, lane_cnt} + (CW+1)'(pend);
    assign fifo_rd_en = rst_n && (state == FILL) && !fifo_empty &&
                        (fill_level < (CW+1)'(PACK_RATIO)) && !flush_q;
    assign last_lane  = pend && (lane_cnt == CW'(PACK_RATIO - 1));

    // Lanes above lane_cnt are always zero, so OR-ing in the returning word
    // gives the complete packed word on the same edge it is captured.
    assign merged_word = lane_word | (OW'(fifo_data) << (lane_cnt * DATA_WIDTH));

`ifdef PACKER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [IW-1:0] idle_cnt;
    logic          timeout_hit;

    assign timeout_hit = (idle_cnt == IW'(TIMEOUT_CYCLES));
    assign flush_req   = flush || flush_q || timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if ((state != FILL) || fifo_rd_en || pend || timeout_hit) begin
            idle_cnt <= '0;
        end else if (lane_cnt != '0) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end
`else
    assign flush_req = flush || flush_q;
`endif

    packer_lane_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .PACK_RATIO (PACK_RATIO)
    ) u_lanes (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     ((state == OUT) && out_ready),
        .wr_en   (pend && (state == FILL)),
        .wr_idx  (lane_cnt),
        .wr_data (fifo_data),
        .word    (lane_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            lane_cnt  <= '0;
            pend      <= 1'b0;
            flush_q   <= 1'b0;
            out_data  <= '0;
            out_lanes <= '0;
            out_valid <= 1'b0;
        end else begin
            pend <= fifo_rd_en;
            case (state)
                FILL: begin
                    if (pend) begin
                        lane_cnt <= lane_cnt + CW'(1);
                        if (last_lane) begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                            out_data  <= merged_word;
                            out_lanes <= CW'(PACK_RATIO);
                            flush_q   <= 1'b0;
                        end else if (flush_req) begin
                            flush_q <= 1'b1;
                        end
                    end else if (flush_req) begin
                        if (lane_cnt == '0) begin
                            flush_q <= 1'b0;
                        end else if (fifo_rd_en) begin
                            // A pop is being issued this cycle; wait for its data
                            flush_q <= 1'b1;
                        end else begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                            out_data  <= lane_word;
                            out_lanes <= lane_cnt;
                            flush_q   <= 1'b0;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= FILL;
                        out_valid <= 1'b0;
                        lane_cnt  <= '0;
                        flush_q   <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed self-checking bench for fifo_rd_packer driving a behavioural FIFO
// with a one-cycle registered read port.
module tb_fifo_rd_packer;
    import fifo_pack::*;

    localparam int DW = 16;
    localparam int PR = 4;
    localparam int OW = DW * PR;
    localparam int LW = $clog2(PR) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          flush = 1'b0;
    logic [OW-1:0] out_data;
    logic [LW-1:0] out_lanes;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_mem [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    logic [OW-1:0] acc_data [0:63];
    int            acc_lanes [0:63];
    int            acc_cnt = 0;
    int            runs [0:63];
    int            nruns = 0;
    int            run_len = 0;
    int            underflow_cnt = 0;

    fifo_rd_packer #(
        .DATA_WIDTH     (DW),
        .PACK_RATIO     (PR),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .out_data   (out_data),
        .out_lanes  (out_lanes),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_data <= fifo_mem[rd_ptr % 256];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Record accepted words, read-enable burst lengths and underflow attempts
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd_en && fifo_empty) underflow_cnt++;
            if (out_valid && out_ready && acc_cnt < 64) begin
                acc_data[acc_cnt]  = out_data;
                acc_lanes[acc_cnt] = int'(out_lanes);
                acc_cnt++;
            end
            if (fifo_rd_en) begin
                run_len++;
            end else if (run_len > 0) begin
                if (nruns < 64) runs[nruns] = run_len;
                nruns++;
                run_len = 0;
            end
        end
    end

    task automatic check_output(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [DW-1:0] w);
        fifo_mem[wr_ptr % 256] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    int  base;
    int  rbase;
    bit  seen;

    initial begin
        // Reset with a word waiting in the FIFO: no read may be issued
        apply_stimulus(16'hDEAD);
        repeat (2) sample();
        check_output("reset_valid", 64'(out_valid), 64'd0);
        check_output("reset_lanes", 64'(out_lanes), 64'd0);
        check_output("reset_data", out_data, 64'd0);
        check_output("reset_rd_en", 64'(fifo_rd_en), 64'd0);
        wr_ptr = rd_ptr;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Eight streamed words become two full output words
        $display("[TB] streaming 8 words");
        base  = acc_cnt;
        rbase = nruns;
        for (int i = 1; i <= 8; i++) apply_stimulus(DW'(i));
        repeat (20) step();
        check_output("stream_count", 64'(acc_cnt - base), 64'd2);
        check_output("stream_data0", acc_data[base], 64'h0004_0003_0002_0001);
        check_output("stream_lanes0", 64'(acc_lanes[base]), 64'd4);
        check_output("stream_data1", acc_data[base+1], 64'h0008_0007_0006_0005);
        check_output("stream_lanes1", 64'(acc_lanes[base+1]), 64'd4);
        check_output("stream_runs", 64'(nruns - rbase), 64'd2);
        check_output("stream_run0", 64'(runs[rbase]), 64'd4);
        check_output("stream_run1", 64'(runs[rbase+1]), 64'd4);

        // Three words then a flush once all are captured
        $display("[TB] partial flush after capture");
        apply_stimulus(16'h00A1);
        apply_stimulus(16'h00A2);
        apply_stimulus(16'h00A3);
        repeat (5) step();
        sample();
        check_output("part_hold_valid", 64'(out_valid), 64'd0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        sample();
        check_output("part_valid", 64'(out_valid), 64'd1);
        check_output("part_data", out_data, 64'h0000_00A3_00A2_00A1);
        check_output("part_lanes", 64'(out_lanes), 64'd3);
        repeat (2) step();

        // Flush in the cycle the third pop is issued, with a capture pending
        $display("[TB] flush with pending capture");
        apply_stimulus(16'h00B1);
        apply_stimulus(16'h00B2);
        apply_stimulus(16'h00B3);
        step();
        step();
        flush = 1'b1;
        sample();
        check_output("defer_third_pop", 64'(fifo_rd_en), 64'd1);
        step();
        flush = 1'b0;
        sample();
        check_output("defer_not_yet", 64'(out_valid), 64'd0);
        step();
        step();
        sample();
        check_output("defer_valid", 64'(out_valid), 64'd1);
        check_output("defer_lanes", 64'(out_lanes), 64'd3);
        check_output("defer_data", out_data, 64'h0000_00B3_00B2_00B1);
        repeat (2) step();
        check_output("defer_fifo_drained", 64'(fifo_empty), 64'd1);

        // Back-pressure: full word held while out_ready is low
        $display("[TB] back-pressure hold");
        out_ready = 1'b0;
        base = acc_cnt;
        for (int i = 1; i <= 6; i++) apply_stimulus(16'h00C0 + DW'(i));
        repeat (5) step();
        sample();
        check_output("bp_valid", 64'(out_valid), 64'd1);
        check_output("bp_data", out_data, 64'h00C4_00C3_00C2_00C1);
        check_output("bp_lanes", 64'(out_lanes), 64'd4);
        for (int i = 0; i < 10; i++) begin
            step();
            sample();
            check_output("bp_hold_valid", 64'(out_valid), 64'd1);
            check_output("bp_hold_data", out_data, 64'h00C4_00C3_00C2_00C1);
            check_output("bp_hold_rd_en", 64'(fifo_rd_en), 64'd0);
        end
        step();
        out_ready = 1'b1;
        step();
        sample();
        check_output("bp_accepted", 64'(out_valid), 64'd0);
        check_output("bp_next_pop", 64'(fifo_rd_en), 64'd1);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (3) step();
        check_output("bp_count", 64'(acc_cnt - base), 64'd2);
        check_output("bp_first", acc_data[base], 64'h00C4_00C3_00C2_00C1);
        check_output("bp_tail_data", acc_data[base+1], 64'h0000_0000_00C6_00C5);
        check_output("bp_tail_lanes", 64'(acc_lanes[base+1]), 64'd2);

        // Asynchronous reset while two lanes are filled and a capture is pending
        $display("[TB] reset mid-fill");
        for (int i = 1; i <= 4; i++) apply_stimulus(16'h00D0 + DW'(i));
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check_output("mid_rst_valid", 64'(out_valid), 64'd0);
        wr_ptr = rd_ptr;
        step();
        rst_n = 1'b1;
        base = acc_cnt;
        for (int i = 1; i <= 4; i++) apply_stimulus(16'h00E0 + DW'(i));
        repeat (10) step();
        check_output("post_rst_count", 64'(acc_cnt - base), 64'd1);
        check_output("post_rst_data", acc_data[base], 64'h00E4_00E3_00E2_00E1);
        check_output("post_rst_lanes", 64'(acc_lanes[base]), 64'd4);

        // Single captured word followed by an idle, empty FIFO
        $display("[TB] idle partial word");
        base = acc_cnt;
        apply_stimulus(16'h00F1);
        repeat (3) step();
        seen = 1'b0;
`ifdef PACKER_TIMEOUT_EN
        for (int i = 0; i < 40 && !seen; i++) begin
            sample();
            if (out_valid) seen = 1'b1;
            step();
        end
        check_output("timeout_fired", 64'(seen), 64'd1);
`else
        for (int i = 0; i < 100; i++) begin
            sample();
            if (out_valid) seen = 1'b1;
            step();
        end
        check_output("idle_no_output", 64'(seen), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
`endif
        repeat (3) step();
        check_output("idle_count", 64'(acc_cnt - base), 64'd1);
        check_output("idle_data", acc_data[base], 64'h0000_0000_0000_00F1);
        check_output("idle_lanes", 64'(acc_lanes[base]), 64'd1);

        check_output("no_underflow", 64'(underflow_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
